// File: rtl/shift_normalizer.sv
// Multi-cycle normalizer: left-shifts a WIDTH-bit operand until normalized, reporting the shift count.
// Define NORM_FAST2_EN to allow two-bit steps per cycle when both positions are non-normalized.
module shift_normalizer #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ain,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] yout,
  output logic [CNTW-1:0]  count,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [CNTW-1:0]  cnt;
  logic             smode;
  logic             norm;
  logic             capped;
  logic             fast2;

  // The cap stops operands such as signed 0xFFFF that never reach a normalized form.
  always_comb begin
    norm   = smode ? (work[WIDTH-1] != work[WIDTH-2]) : work[WIDTH-1];
    capped = (cnt == CNTW'(WIDTH - 1));
`ifdef NORM_FAST2_EN
    fast2  = (cnt <= CNTW'(WIDTH - 3)) &&
             (smode ? (work[WIDTH-2] == work[WIDTH-3]) : !work[WIDTH-2]);
`else
    fast2  = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
      smode <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      yout  <= '0;
      count <= '0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work  <= ain;
            cnt   <= '0;
            smode <= signed_mode;
            busy  <= 1'b1;
            yout  <= '0;
            count <= '0;
            zero  <= 1'b0;
            if (ain == '0) begin
              zero  <= 1'b1;
              count <= CNTW'(WIDTH);
              state <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (norm || capped) begin
            yout  <= work;
            count <= cnt;
            done  <= 1'b1;
            state <= DONE;
          end else if (fast2) begin
            work <= work << 2;
            cnt  <= cnt + CNTW'(2);
          end else begin
            work <= work << 1;
            cnt  <= cnt + CNTW'(1);
          end
        end
        // A zero operand arrives here with done still low, so it spends one extra cycle.
        DONE: begin
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_normalizer.sv
// Self-checking bench for shift_normalizer: directed operations scored through an expectation queue.
// Latency expectations follow NORM_FAST2_EN when it is defined.
module tb_shift_normalizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [15:0] ain = 16'h0000;
  logic        busy;
  logic        done;
  logic        zero;
  logic [15:0] yout;
  logic [4:0]  count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acceptCyc = 0;

  typedef struct {
    logic [15:0] y;
    logic [4:0]  c;
    logic        z;
    int          lat;
  } exp_t;

  exp_t sb[$];

  shift_normalizer #(.WIDTH(16), .CNTW(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .ain(ain),
    .signed_mode(signed_mode),
    .busy(busy),
    .done(done),
    .yout(yout),
    .count(count),
    .zero(zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int expLatency(input logic [4:0] c, input logic z);
    if (z) return 1;
`ifdef NORM_FAST2_EN
    return (int'(c) + 1) / 2 + 1;
`else
    return int'(c) + 1;
`endif
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled on the following posedge.
  task automatic applyStimulus(input logic [15:0] a, input logic m,
                               input logic [15:0] ey, input logic [4:0] ec, input logic ez);
    exp_t e;
    start = 1'b1;
    ain = a;
    signed_mode = m;
    e.y = ey;
    e.c = ec;
    e.z = ez;
    e.lat = expLatency(ec, ez);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    ain = ~a;
    signed_mode = ~m;
    acceptCyc = cyc;
    checkValue("busy_at_accept", {31'd0, busy}, 32'd1);
    if (!ez) begin
      checkValue("yout_cleared_at_accept", {16'd0, yout}, 32'd0);
      checkValue("count_cleared_at_accept", {27'd0, count}, 32'd0);
      checkValue("zero_cleared_at_accept", {31'd0, zero}, 32'd0);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    int lat;
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    lat = cyc - acceptCyc;
    checkValue({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    if (sb.size() == 0) begin
      checkValue({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (seen) begin
      checkValue({tag, "_yout"}, {16'd0, yout}, {16'd0, e.y});
      checkValue({tag, "_count"}, {27'd0, count}, {27'd0, e.c});
      checkValue({tag, "_zero"}, {31'd0, zero}, {31'd0, e.z});
      checkValue({tag, "_latency"}, lat, e.lat);
      checkValue({tag, "_busy_with_done"}, {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    checkValue({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    checkValue({tag, "_busy_dropped"}, {31'd0, busy}, 32'd0);
    checkValue({tag, "_yout_hold"}, {16'd0, yout}, {16'd0, e.y});
    checkValue({tag, "_count_hold"}, {27'd0, count}, {27'd0, e.c});
  endtask

  initial begin
    int doneSeen;
    $display("[TB] shift_normalizer bench starting");

    repeat (2) @(negedge clk);
    checkValue("reset_busy", {31'd0, busy}, 32'd0);
    checkValue("reset_done", {31'd0, done}, 32'd0);
    checkValue("reset_yout", {16'd0, yout}, 32'd0);
    checkValue("reset_count", {27'd0, count}, 32'd0);
    checkValue("reset_zero", {31'd0, zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(16'h0FD6, 1'b0, 16'hFD60, 5'd4, 1'b0);
    checkOutput("t1_unsigned_0fd6");
    applyStimulus(16'hCFD6, 1'b1, 16'h9FAC, 5'd1, 1'b0);
    checkOutput("t2_signed_cfd6");
    applyStimulus(16'h0000, 1'b0, 16'h0000, 5'd16, 1'b1);
    checkOutput("t3_zero_unsigned");
    applyStimulus(16'h0000, 1'b1, 16'h0000, 5'd16, 1'b1);
    checkOutput("t3_zero_signed");
    applyStimulus(16'hFFFF, 1'b1, 16'h8000, 5'd15, 1'b0);
    checkOutput("t4_signed_ffff");
    applyStimulus(16'h8001, 1'b0, 16'h8001, 5'd0, 1'b0);
    checkOutput("t4_unsigned_8001");
    applyStimulus(16'h0001, 1'b1, 16'h4000, 5'd14, 1'b0);
    checkOutput("x_signed_0001");
    applyStimulus(16'h4000, 1'b0, 16'h8000, 5'd1, 1'b0);
    checkOutput("x_unsigned_4000");
    applyStimulus(16'h7FFF, 1'b1, 16'h7FFF, 5'd0, 1'b0);
    checkOutput("x_signed_7fff");

    // A second start mid-operation must not disturb the running one.
    applyStimulus(16'h0001, 1'b0, 16'h8000, 5'd15, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    ain = 16'h1234;
    signed_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkValue("t5b_busy_after_ignored_start", {31'd0, busy}, 32'd1);
    checkOutput("t5b_unsigned_0001");

    applyStimulus(16'h00F0, 1'b0, 16'hF000, 5'd8, 1'b0);
    checkOutput("t6_back_to_back");

    // Reset mid-operation: outputs clear at once and no done pulse ever follows.
    start = 1'b1;
    ain = 16'h0001;
    signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checkValue("t5c_busy_before_reset", {31'd0, busy}, 32'd1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkValue("t5c_busy_in_reset", {31'd0, busy}, 32'd0);
    checkValue("t5c_done_in_reset", {31'd0, done}, 32'd0);
    checkValue("t5c_yout_in_reset", {16'd0, yout}, 32'd0);
    checkValue("t5c_count_in_reset", {27'd0, count}, 32'd0);
    checkValue("t5c_zero_in_reset", {31'd0, zero}, 32'd0);
    doneSeen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      if (done !== 1'b0) doneSeen++;
    end
    checkValue("t5c_no_done_after_reset", doneSeen, 0);
    checkValue("t5c_busy_after_release", {31'd0, busy}, 32'd0);
    checkValue("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
